// File: rtl/ads1299_cmd_tx_if.sv
// ads1299_cmd_tx_if
//   Command byte stream into the ADS1299 command transmitter.
//   cmd_data  : command byte, sent MSB first
//   cmd_valid : cmd_data is valid
//   cmd_last  : byte closes the frame (chip select released after it)
//   cmd_ready : transmitter accepts a byte this cycle
//   master    : producer of command bytes
//   slave     : the transmitter
interface ads1299_cmd_tx_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_last;
    logic       cmd_ready;

    modport master (
        output cmd_data,
        output cmd_valid,
        output cmd_last,
        input  cmd_ready
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        input  cmd_last,
        output cmd_ready
    );
endinterface

// File: rtl/ads1299_cmd_tx.sv
// ads1299_cmd_tx
//   SPI command transmitter for the ADS1299 (host to device). Each frame of command
//   bytes is sent under one chip-select assertion, SPI mode 1 (SCLK idles low, MOSI
//   changes on the rising edge, MISO is sampled on the falling edge), with a decode
//   gap between bytes.
//
//   Optional build macro ADS_CMD_READBACK_EN: when defined, MISO is captured MSB
//   first and every completed byte is presented on rx_data with an rx_valid pulse.
//   When undefined, rx_data/rx_valid are held at 0 and ads_miso is ignored.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   cmd        : command byte stream (slave side of ads1299_cmd_tx_if)
//   ads_sclk   : SPI clock, idle low
//   ads_cs_n   : chip select, active low
//   ads_mosi   : serial data to the device
//   ads_miso   : serial data from the device
//   busy       : high whenever the transmitter is not idle (used to mux the SPI bus)
//   frame_done : one-cycle pulse when a frame completes (cs_n released)
//   rx_data    : last byte captured from MISO
//   rx_valid   : one-cycle pulse, rx_data updated
module ads1299_cmd_tx #(
    parameter int unsigned CLK_DIV  = 25,
    parameter int unsigned BYTE_GAP = 100,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 8,
    parameter int unsigned CS_IDLE  = 50
) (
    input  logic                   clk,
    input  logic                   rst,
    ads1299_cmd_tx_if.slave        cmd,
    output logic                   ads_sclk,
    output logic                   ads_cs_n,
    output logic                   ads_mosi,
    input  logic                   ads_miso,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             rx_data,
    output logic                   rx_valid
);

    localparam int unsigned MAX_0 = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
    localparam int unsigned MAX_1 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned MAX_2 = (MAX_0 > MAX_1) ? MAX_0 : MAX_1;
    localparam int unsigned MAX_P = (MAX_2 > CS_IDLE) ? MAX_2 : CS_IDLE;
    localparam int unsigned CNT_W = $clog2(MAX_P + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX   = cnt_t'(MAX_P);
    localparam cnt_t DIV_END   = cnt_t'(CLK_DIV - 1);
    localparam cnt_t SETUP_END = cnt_t'(CS_SETUP - 1);
    localparam cnt_t HOLD_END  = cnt_t'(CS_HOLD - 1);
    localparam cnt_t IDLE_END  = cnt_t'(CS_IDLE - 1);
    localparam cnt_t GAP_END   = cnt_t'(BYTE_GAP);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StGap,
        StHold,
        StOff
    } state_e;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d, cnt_sat;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic       last_q, last_d;
    logic       sclk_q, sclk_d;
    logic       cs_n_q, cs_n_d;
    logic       mosi_q, mosi_d;
    logic       done_q, done_d;
    logic       ready;
    logic       accept;

    // Ready is gated by rst so it reads 0 while reset is held, even though the
    // reset state is IDLE.
    assign ready = !rst && ((state_q == StIdle) || ((state_q == StGap) && (cnt_q >= GAP_END)));
    assign cmd.cmd_ready = ready;
    assign accept = cmd.cmd_valid && ready;

    // Shared phase counter; saturates instead of wrapping.
    assign cnt_sat = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);

`ifdef ADS_CMD_READBACK_EN
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
`else
    logic unused_miso;
    assign unused_miso = ads_miso;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_sat;
        bit_d   = bit_q;
        tx_d    = tx_q;
        last_d  = last_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
`ifdef ADS_CMD_READBACK_EN
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (accept) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    tx_d    = cmd.cmd_data;
                    last_d  = cmd.cmd_last;
                    cnt_d   = '0;
                end
            end
            StSetup: begin
                // Leaving SETUP is the first rising SCLK of the frame.
                if (cnt_q == SETUP_END) begin
                    state_d = StShift;
                    sclk_d  = 1'b1;
                    mosi_d  = tx_q[7];
                    bit_d   = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (cnt_q == DIV_END) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: sample MISO, advance TX.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[6:0], 1'b0};
`ifdef ADS_CMD_READBACK_EN
                        rx_sr_d = {rx_sr_q[6:0], ads_miso};
`endif
                        if (bit_q == 3'd7) begin
                            state_d = last_q ? StHold : StGap;
`ifdef ADS_CMD_READBACK_EN
                            rx_data_d  = {rx_sr_q[6:0], ads_miso};
                            rx_valid_d = 1'b1;
`endif
                        end
                    end else begin
                        // Rising edge: next bit onto MOSI.
                        sclk_d = 1'b1;
                        mosi_d = tx_q[7];
                        bit_d  = bit_q + 3'd1;
                    end
                end
            end
            StGap: begin
                sclk_d = 1'b0;
                if (accept) begin
                    state_d = StShift;
                    sclk_d  = 1'b1;
                    mosi_d  = cmd.cmd_data[7];
                    tx_d    = cmd.cmd_data;
                    last_d  = cmd.cmd_last;
                    bit_d   = '0;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (cnt_q == HOLD_END) begin
                    state_d = StOff;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            StOff: begin
                if (cnt_q == IDLE_END) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            last_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            last_q  <= last_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

`ifdef ADS_CMD_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`else
    assign rx_data  = 8'h00;
    assign rx_valid = 1'b0;
`endif

    assign ads_sclk   = sclk_q;
    assign ads_cs_n   = cs_n_q;
    assign ads_mosi   = mosi_q;
    assign frame_done = done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ads1299_cmd_tx.sv
module tb_ads1299_cmd_tx;

    localparam int CLK_DIV  = 25;
    localparam int BYTE_GAP = 100;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 8;
    localparam int CS_IDLE  = 50;

    logic       clk;
    logic       rst;
    logic       ads_sclk;
    logic       ads_cs_n;
    logic       ads_mosi;
    logic       ads_miso;
    logic       busy;
    logic       frame_done;
    logic [7:0] rx_data;
    logic       rx_valid;

    ads1299_cmd_tx_if cmd_if ();

    ads1299_cmd_tx #(
        .CLK_DIV  (CLK_DIV),
        .BYTE_GAP (BYTE_GAP),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_IDLE  (CS_IDLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .ads_sclk   (ads_sclk),
        .ads_cs_n   (ads_cs_n),
        .ads_mosi   (ads_mosi),
        .ads_miso   (ads_miso),
        .busy       (busy),
        .frame_done (frame_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed bus events, stamped with the cycle in which they are first seen.
    int         accept_q[$];
    int         rise_q[$];
    int         fall_q[$];
    int         cs_fall_q[$];
    int         cs_rise_q[$];
    int         done_q[$];
    int         busy_fall_q[$];
    logic       mosi_q[$];
    logic [7:0] rx_q[$];
    int         bad_sclk    = 0;
    int         early_ready = 0;

    logic sclk_p = 1'b0;
    logic cs_p   = 1'b1;
    logic busy_p = 1'b0;
    logic mosi_p = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) accept_q.push_back(cyc);
            if (ads_sclk && !sclk_p) rise_q.push_back(cyc);
            if (!ads_sclk && sclk_p) begin
                fall_q.push_back(cyc);
                mosi_q.push_back(mosi_p);
            end
            if (!ads_cs_n && cs_p) cs_fall_q.push_back(cyc);
            if (ads_cs_n && !cs_p) cs_rise_q.push_back(cyc);
            if (frame_done) done_q.push_back(cyc);
            if (!busy && busy_p) busy_fall_q.push_back(cyc);
            if (rx_valid) rx_q.push_back(rx_data);
            if (ads_sclk && ads_cs_n) bad_sclk <= bad_sclk + 1;
            if (cmd_if.cmd_ready && busy &&
                ((fall_q.size() == 0) || (cyc - fall_q[$] < BYTE_GAP)))
                early_ready <= early_ready + 1;
        end
        sclk_p <= ads_sclk;
        cs_p   <= ads_cs_n;
        busy_p <= busy;
        mosi_p <= ads_mosi;
    end

    // Device model: shifts miso_bytes out MSB first, changing on rising SCLK.
    logic [7:0] miso_bytes [8];
    int         miso_idx;

    initial begin
        ads_miso = 1'b0;
        miso_idx = 0;
        forever begin
            @(posedge ads_sclk or posedge ads_cs_n);
            if (ads_cs_n) begin
                miso_idx = 0;
            end else if (miso_idx < 64) begin
                ads_miso = miso_bytes[miso_idx / 8][7 - (miso_idx % 8)];
                miso_idx++;
            end
        end
    end

    initial begin
        #1_600_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        accept_q.delete();
        rise_q.delete();
        fall_q.delete();
        cs_fall_q.delete();
        cs_rise_q.delete();
        done_q.delete();
        busy_fall_q.delete();
        mosi_q.delete();
        rx_q.delete();
    endtask

    task automatic randomize_miso();
        for (int i = 0; i < 8; i++) miso_bytes[i] = 8'($urandom);
    endtask

    // Offer one byte until accepted. With junk set, cmd_data is scrambled on every
    // cycle that cmd_ready is low; keep_valid leaves cmd_valid high afterwards.
    task automatic send_byte(input logic [7:0] data, input logic last,
                             input bit junk, input bit keep_valid);
        bit got;
        got = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_last  = last;
        cmd_if.cmd_data  = junk ? 8'($urandom) : data;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready) begin
                cmd_if.cmd_data = data;
                got = 1'b1;
            end else if (junk) begin
                cmd_if.cmd_data = 8'($urandom);
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            check("accept_timeout", 0, 1);
        end
        if (!keep_valid || !got) cmd_if.cmd_valid = 1'b0;
    endtask

    logic [7:0] frame_q[$];

    task automatic wait_idle();
        for (int i = 0; i < 1000 && busy_fall_q.size() == 0; i++) @(negedge clk);
        check("frame_end_seen", busy_fall_q.size(), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Expected bus behaviour of a frame derived from the timing rules alone.
    task automatic check_frame();
        int n;
        int bad;
        logic [7:0] b;
        n = frame_q.size();
        check("accepts", accept_q.size(), n);
        check("cs_falls", cs_fall_q.size(), 1);
        check("cs_rises", cs_rise_q.size(), 1);
        check("rises", rise_q.size(), 8 * n);
        check("falls", fall_q.size(), 8 * n);
        check("frame_done", done_q.size(), 1);
        if (accept_q.size() == n && cs_fall_q.size() == 1 && cs_rise_q.size() == 1 &&
            rise_q.size() == 8 * n && fall_q.size() == 8 * n && done_q.size() == 1 &&
            busy_fall_q.size() >= 1) begin
            check("cs_fall_delay", cs_fall_q[0] - accept_q[0], 1);
            check("cs_setup", rise_q[0] - cs_fall_q[0], CS_SETUP);
            bad = 0;
            for (int i = 0; i < 8 * n; i++) begin
                if (fall_q[i] - rise_q[i] != CLK_DIV) bad++;
                if ((i % 8 != 0) && (rise_q[i] - rise_q[i-1] != 2 * CLK_DIV)) bad++;
            end
            check("bit_timing", bad, 0);
            for (int j = 1; j < n; j++) begin
                check("gap_min", int'(rise_q[8*j] - fall_q[8*j-1] >= BYTE_GAP), 1);
                check("accept_to_rise", rise_q[8*j] - accept_q[j], 1);
            end
            for (int j = 0; j < n; j++) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++) b = {b[6:0], mosi_q[8*j+k]};
                check("mosi_byte", int'(b), int'(frame_q[j]));
            end
            check("cs_hold", cs_rise_q[0] - fall_q[8*n-1], CS_HOLD);
            check("done_at_cs_rise", done_q[0] - cs_rise_q[0], 0);
            check("cs_idle", busy_fall_q[0] - cs_rise_q[0], CS_IDLE);
        end
`ifdef ADS_CMD_READBACK_EN
        check("rx_count", rx_q.size(), n);
        for (int j = 0; j < n && j < rx_q.size(); j++)
            check("rx_data", int'(rx_q[j]), int'(miso_bytes[j]));
`else
        check("rx_count", rx_q.size(), 0);
`endif
        check("sclk_outside_cs", bad_sclk, 0);
        check("early_ready", early_ready, 0);
        check("mosi_idle", int'(ads_mosi), 0);
    endtask

    task automatic run_frame(input bit junk, input int stall_cycles);
        int n;
        n = frame_q.size();
        clear_mon();
        for (int i = 0; i < n; i++) begin
            send_byte(frame_q[i], (i == n - 1), junk, junk && (i != n - 1));
            if (i == 0 && stall_cycles > 0 && n > 1) begin
                repeat (stall_cycles) @(posedge clk);
                #1;
                check("stall_cs_low", int'(ads_cs_n), 0);
                check("stall_sclk_low", int'(ads_sclk), 0);
                check("stall_rises", rise_q.size(), 8);
                check("stall_busy", int'(busy), 1);
            end
        end
        wait_idle();
        check_frame();
    endtask

    initial begin
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_last  = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        randomize_miso();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", int'(ads_cs_n), 1);
        check("rst_sclk", int'(ads_sclk), 0);
        check("rst_mosi", int'(ads_mosi), 0);
        check("rst_ready", int'(cmd_if.cmd_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", int'(cmd_if.cmd_ready), 1);

        // SDATAC alone
        frame_q = {8'h11};
        randomize_miso();
        run_frame(1'b0, 0);

        // WREG CONFIG3
        frame_q = {8'h43, 8'h00, 8'hE0};
        randomize_miso();
        run_frame(1'b0, 0);

        // Frame held open after the first byte
        frame_q = {8'h41, 8'h96};
        randomize_miso();
        run_frame(1'b0, 1000);

        // RREG ID with the device answering 0x3E on byte 3
        frame_q = {8'h20, 8'h00, 8'h00};
        randomize_miso();
        miso_bytes[2] = 8'h3E;
        run_frame(1'b0, 0);

        // Reset in the middle of bit 4
        clear_mon();
        send_byte(8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2000 && rise_q.size() < 4; i++) @(negedge clk);
        check("reach_bit4", rise_q.size(), 4);
        repeat (5) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_cs_n", int'(ads_cs_n), 1);
        check("async_rst_sclk", int'(ads_sclk), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_mosi", int'(ads_mosi), 0);
        check("async_rst_ready", int'(cmd_if.cmd_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        frame_q = {8'h0A};
        randomize_miso();
        run_frame(1'b0, 0);

        // cmd_valid held with scrambled data while shifting
        frame_q = {8'h45, 8'h01, 8'h02};
        randomize_miso();
        run_frame(1'b1, 0);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(1, 3);
            frame_q.delete();
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            randomize_miso();
            run_frame(1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
